// File: rtl/cdb_reservation_station_if.sv
// Bundle between dispatch / CDB / functional unit and one reservation-station bank.
// The station takes the slave modport; the surrounding pipeline takes master.
interface cdb_reservation_station_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_WIDTH    = 3,
  parameter int ENTRIES      = 4,
  parameter int OPCODE_WIDTH = 4
);
  localparam int OCC_WIDTH = $clog2(ENTRIES + 1);

  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [OPCODE_WIDTH-1:0] alloc_opcode;
  logic [TAG_WIDTH-1:0]    alloc_dest_tag;
  logic                    alloc_src1_rdy;
  logic                    alloc_src2_rdy;
  logic [DATA_WIDTH-1:0]   alloc_src1_val;
  logic [DATA_WIDTH-1:0]   alloc_src2_val;
  logic [TAG_WIDTH-1:0]    alloc_src1_tag;
  logic [TAG_WIDTH-1:0]    alloc_src2_tag;

  logic                    cdb_valid;
  logic [TAG_WIDTH-1:0]    cdb_rs_id;
  logic [DATA_WIDTH-1:0]   cdb_result;

  logic                    iss_valid;
  logic                    iss_ready;
  logic [OPCODE_WIDTH-1:0] iss_opcode;
  logic [DATA_WIDTH-1:0]   iss_op1;
  logic [DATA_WIDTH-1:0]   iss_op2;
  logic [TAG_WIDTH-1:0]    iss_dest_tag;

  logic [OCC_WIDTH-1:0]    occupancy;

  modport master (
    output alloc_valid, alloc_opcode, alloc_dest_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_val, alloc_src2_val,
           alloc_src1_tag, alloc_src2_tag,
           cdb_valid, cdb_rs_id, cdb_result, iss_ready,
    input  alloc_ready, iss_valid, iss_opcode, iss_op1, iss_op2, iss_dest_tag,
           occupancy
  );

  modport slave (
    input  alloc_valid, alloc_opcode, alloc_dest_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_val, alloc_src2_val,
           alloc_src1_tag, alloc_src2_tag,
           cdb_valid, cdb_rs_id, cdb_result, iss_ready,
    output alloc_ready, iss_valid, iss_opcode, iss_op1, iss_op2, iss_dest_tag,
           occupancy
  );
endinterface

// File: rtl/cdb_reservation_station.sv
// Reservation-station bank: holds dispatched micro-ops, captures operands from the CDB
// by tag, and issues the oldest fully-ready entry through a registered valid/ready port.
module cdb_reservation_station #(
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_WIDTH    = 3,
  parameter int ENTRIES      = 4,
  parameter int OPCODE_WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  cdb_reservation_station_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(ENTRIES);
  localparam int OCC_WIDTH = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [TAG_WIDTH-1:0]    dest_tag;
    logic                    src1_rdy;
    logic [DATA_WIDTH-1:0]   src1_val;
    logic [TAG_WIDTH-1:0]    src1_tag;
    logic                    src2_rdy;
    logic [DATA_WIDTH-1:0]   src2_val;
    logic [TAG_WIDTH-1:0]    src2_tag;
  } slot_t;

  slot_t              slot_q  [ENTRIES];
  logic [ENTRIES-1:0] occ_q;
  // older_q[i][j] set: slot i was allocated before slot j.
  logic [ENTRIES-1:0] older_q [ENTRIES];

  logic                    iss_valid_q;
  logic [OPCODE_WIDTH-1:0] iss_opcode_q;
  logic [DATA_WIDTH-1:0]   iss_op1_q;
  logic [DATA_WIDTH-1:0]   iss_op2_q;
  logic [TAG_WIDTH-1:0]    iss_dest_tag_q;

  logic [ENTRIES-1:0]   elig;
  logic [ENTRIES-1:0]   sel_vec;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [IDX_WIDTH-1:0] free_idx;
  logic [OCC_WIDTH-1:0] occ_cnt;
  logic                 alloc_ready;
  logic                 do_alloc;
  logic                 iss_load;
  logic [ENTRIES-1:0]   clear_mask;
  logic [ENTRIES-1:0]   set_mask;
  slot_t                alloc_slot;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    elig     = '0;
    sel_vec  = '0;
    sel_idx  = '0;
    free_idx = '0;
    occ_cnt  = '0;
    for (int i = 0; i < ENTRIES; i++)
      elig[i] = occ_q[i] & slot_q[i].src1_rdy & slot_q[i].src2_rdy;
    // A slot wins when no other eligible slot is older than it.
    for (int i = 0; i < ENTRIES; i++) begin
      sel_vec[i] = elig[i];
      for (int j = 0; j < ENTRIES; j++)
        if (j != i && elig[j] && older_q[j][i]) sel_vec[i] = 1'b0;
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (sel_vec[i]) sel_idx = IDX_WIDTH'(i);
      if (!occ_q[i])  free_idx = IDX_WIDTH'(i);
      occ_cnt = occ_cnt + OCC_WIDTH'(occ_q[i]);
    end
  end

  assign alloc_ready = occ_cnt < OCC_WIDTH'(ENTRIES);
  assign do_alloc    = bus.alloc_valid && alloc_ready;
  assign iss_load    = (!iss_valid_q || bus.iss_ready) && (|elig);
  assign clear_mask  = iss_load ? sel_vec : '0;
  assign set_mask    = do_alloc ? (ENTRIES'(1) << free_idx) : '0;

  // Incoming micro-op, with operands already on the CDB this cycle captured directly.
  always_comb begin
    alloc_slot.opcode   = bus.alloc_opcode;
    alloc_slot.dest_tag = bus.alloc_dest_tag;
    alloc_slot.src1_rdy = bus.alloc_src1_rdy;
    alloc_slot.src1_val = bus.alloc_src1_val;
    alloc_slot.src1_tag = bus.alloc_src1_tag;
    alloc_slot.src2_rdy = bus.alloc_src2_rdy;
    alloc_slot.src2_val = bus.alloc_src2_val;
    alloc_slot.src2_tag = bus.alloc_src2_tag;
    if (bus.cdb_valid && !bus.alloc_src1_rdy && bus.alloc_src1_tag == bus.cdb_rs_id) begin
      alloc_slot.src1_rdy = 1'b1;
      alloc_slot.src1_val = bus.cdb_result;
    end
    if (bus.cdb_valid && !bus.alloc_src2_rdy && bus.alloc_src2_tag == bus.cdb_rs_id) begin
      alloc_slot.src2_rdy = 1'b1;
      alloc_slot.src2_val = bus.cdb_result;
    end
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q          <= '0;
      iss_valid_q    <= 1'b0;
      iss_opcode_q   <= '0;
      iss_op1_q      <= '0;
      iss_op2_q      <= '0;
      iss_dest_tag_q <= '0;
    end else if (flush) begin
      occ_q          <= '0;
      iss_valid_q    <= 1'b0;
      iss_opcode_q   <= '0;
      iss_op1_q      <= '0;
      iss_op2_q      <= '0;
      iss_dest_tag_q <= '0;
    end else begin
      occ_q <= (occ_q & ~clear_mask) | set_mask;
      if (iss_load) begin
        iss_valid_q    <= 1'b1;
        iss_opcode_q   <= slot_q[sel_idx].opcode;
        iss_op1_q      <= slot_q[sel_idx].src1_val;
        iss_op2_q      <= slot_q[sel_idx].src2_val;
        iss_dest_tag_q <= slot_q[sel_idx].dest_tag;
      end else if (bus.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: slot payload and age bits carry no reset; occ_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (do_alloc && free_idx == IDX_WIDTH'(i)) begin
        slot_q[i]  <= alloc_slot;
        older_q[i] <= '0;
      end else begin
        if (occ_q[i] && bus.cdb_valid) begin
          if (!slot_q[i].src1_rdy && slot_q[i].src1_tag == bus.cdb_rs_id) begin
            slot_q[i].src1_rdy <= 1'b1;
            slot_q[i].src1_val <= bus.cdb_result;
          end
          if (!slot_q[i].src2_rdy && slot_q[i].src2_tag == bus.cdb_rs_id) begin
            slot_q[i].src2_rdy <= 1'b1;
            slot_q[i].src2_val <= bus.cdb_result;
          end
        end
        // Everything already in the bank is older than the newcomer.
        if (do_alloc) older_q[i][free_idx] <= 1'b1;
      end
    end
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.occupancy    = occ_cnt;
  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_opcode   = iss_opcode_q;
  assign bus.iss_op1      = iss_op1_q;
  assign bus.iss_op2      = iss_op2_q;
  assign bus.iss_dest_tag = iss_dest_tag_q;
endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed bench for cdb_reservation_station: expected issues are queued by the stimulus
// and popped by a negedge monitor; cycle-level timing and control outputs are checked inline.
module tb_cdb_reservation_station;
  logic clk;
  logic rst_n;
  logic flush;

  cdb_reservation_station_if bus ();

  cdb_reservation_station dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] d);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [3:0] op, input logic [2:0] dest,
                           input logic r1, input logic [63:0] v1, input logic [2:0] t1,
                           input logic r2, input logic [63:0] v2, input logic [2:0] t2);
    bus.alloc_valid    = 1'b1;
    bus.alloc_opcode   = op;
    bus.alloc_dest_tag = dest;
    bus.alloc_src1_rdy = r1;
    bus.alloc_src1_val = v1;
    bus.alloc_src1_tag = t1;
    bus.alloc_src2_rdy = r2;
    bus.alloc_src2_val = v2;
    bus.alloc_src2_tag = t2;
  endtask

  task automatic set_cdb(input logic [2:0] id, input logic [63:0] res);
    bus.cdb_valid  = 1'b1;
    bus.cdb_rs_id  = id;
    bus.cdb_result = res;
  endtask

  task automatic quiet();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic fill_ready_four();
    set_alloc(4'd2, 3'd1, 1'b1, 64'h1, 3'd0, 1'b1, 64'h2, 3'd0); tick();
    set_alloc(4'd3, 3'd2, 1'b1, 64'h3, 3'd0, 1'b1, 64'h4, 3'd0); tick();
    set_alloc(4'd4, 3'd3, 1'b1, 64'h5, 3'd0, 1'b1, 64'h6, 3'd0); tick();
    set_alloc(4'd5, 3'd4, 1'b1, 64'h7, 3'd0, 1'b1, 64'h8, 3'd0); tick();
    quiet();
  endtask

  // Monitor: a transfer happens at the posedge following a negedge that sees valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.iss_valid && bus.iss_ready) begin
        check("issue_was_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("issue_opcode", 64'(bus.iss_opcode), 64'(e.op));
          check("issue_op1", bus.iss_op1, e.a);
          check("issue_op2", bus.iss_op2, e.b);
          check("issue_dest_tag", 64'(bus.iss_dest_tag), 64'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.iss_ready = 1'b0;
    set_alloc(4'd0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0, 64'h0, 3'd0);
    bus.cdb_rs_id  = 3'd0;
    bus.cdb_result = 64'h0;
    quiet();

    // Reset / idle
    #12;
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_iss_opcode", 64'(bus.iss_opcode), 64'd0);
    check("rst_iss_op1", bus.iss_op1, 64'd0);
    check("rst_iss_dest", 64'(bus.iss_dest_tag), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    check("idle_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("idle_iss_valid", 64'(bus.iss_valid), 64'd0);

    // Basic issue: alloc in N, iss_valid in N+2
    bus.iss_ready = 1'b1;
    set_alloc(4'd3, 3'd1, 1'b1, 64'd5, 3'd0, 1'b1, 64'd7, 3'd0);
    push_exp(4'd3, 64'd5, 64'd7, 3'd1);
    tick(); quiet();
    check("basic_n1_valid", 64'(bus.iss_valid), 64'd0);
    check("basic_n1_occ", 64'(bus.occupancy), 64'd1);
    tick();
    check("basic_n2_valid", 64'(bus.iss_valid), 64'd1);
    check("basic_n2_occ", 64'(bus.occupancy), 64'd0);
    tick();
    check("basic_n3_valid", 64'(bus.iss_valid), 64'd0);

    // Wakeup via CDB, with an unrelated tag broadcast first
    set_alloc(4'd5, 3'd2, 1'b0, 64'h0, 3'd2, 1'b1, 64'd9, 3'd0);
    push_exp(4'd5, 64'h1234, 64'd9, 3'd2);
    tick(); quiet();
    set_cdb(3'd3, 64'hdead);
    tick();
    check("wake_other_tag_no_issue", 64'(bus.iss_valid), 64'd0);
    set_cdb(3'd2, 64'h1234);
    tick(); quiet();
    check("wake_n1_valid", 64'(bus.iss_valid), 64'd0);
    tick();
    check("wake_n2_valid", 64'(bus.iss_valid), 64'd1);
    tick();

    // Allocation-cycle bypass
    set_alloc(4'd6, 3'd3, 1'b0, 64'h0, 3'd4, 1'b1, 64'h11, 3'd0);
    set_cdb(3'd4, 64'hAA);
    push_exp(4'd6, 64'hAA, 64'h11, 3'd3);
    tick(); quiet();
    check("bypass_n1_valid", 64'(bus.iss_valid), 64'd0);
    tick();
    check("bypass_n2_valid", 64'(bus.iss_valid), 64'd1);
    tick();
    check("bypass_n3_valid", 64'(bus.iss_valid), 64'd0);

    // Full bank and age order independent of slot index
    bus.iss_ready = 1'b0;
    set_alloc(4'd7, 3'd4, 1'b1, 64'h70, 3'd0, 1'b1, 64'h71, 3'd0);
    push_exp(4'd7, 64'h70, 64'h71, 3'd4);
    tick();
    set_alloc(4'd8, 3'd5, 1'b0, 64'h0, 3'd1, 1'b1, 64'h81, 3'd0);
    tick();
    check("age_x_loaded", 64'(bus.iss_valid), 64'd1);
    check("age_occ1", 64'(bus.occupancy), 64'd1);
    set_alloc(4'd9, 3'd6, 1'b1, 64'h90, 3'd0, 1'b1, 64'h91, 3'd0);
    push_exp(4'd9, 64'h90, 64'h91, 3'd6);
    tick();
    set_alloc(4'd10, 3'd7, 1'b1, 64'ha0, 3'd0, 1'b0, 64'h0, 3'd1);
    tick();
    set_alloc(4'd11, 3'd0, 1'b0, 64'h0, 3'd1, 1'b0, 64'h0, 3'd1);
    tick();
    check("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    check("full_occupancy", 64'(bus.occupancy), 64'd4);
    set_alloc(4'd15, 3'd7, 1'b1, 64'hff, 3'd0, 1'b1, 64'hff, 3'd0);
    bus.iss_ready = 1'b1;
    tick();
    check("full_reject_occ", 64'(bus.occupancy), 64'd3);
    check("full_r_loaded", 64'(bus.iss_opcode), 64'd9);
    set_alloc(4'd12, 3'd1, 1'b0, 64'h0, 3'd1, 1'b0, 64'h0, 3'd1);
    tick(); quiet();
    check("realloc_occ", 64'(bus.occupancy), 64'd4);
    check("realloc_idle", 64'(bus.iss_valid), 64'd0);
    set_cdb(3'd1, 64'h111);
    push_exp(4'd8, 64'h111, 64'h81, 3'd5);
    push_exp(4'd10, 64'ha0, 64'h111, 3'd7);
    push_exp(4'd11, 64'h111, 64'h111, 3'd0);
    push_exp(4'd12, 64'h111, 64'h111, 3'd1);
    tick(); quiet();
    check("age_capture_no_same_cycle", 64'(bus.iss_valid), 64'd0);
    tick();
    check("age_issue1_dest", 64'(bus.iss_dest_tag), 64'd5);
    tick();
    check("age_issue2_dest", 64'(bus.iss_dest_tag), 64'd7);
    tick();
    check("age_issue3_dest", 64'(bus.iss_dest_tag), 64'd0);
    tick();
    check("age_issue4_dest", 64'(bus.iss_dest_tag), 64'd1);
    check("age_issue4_valid", 64'(bus.iss_valid), 64'd1);
    tick();
    check("age_drained_valid", 64'(bus.iss_valid), 64'd0);
    check("age_drained_occ", 64'(bus.occupancy), 64'd0);

    // Stall: outputs hold, then back-to-back issue
    bus.iss_ready = 1'b0;
    set_alloc(4'd13, 3'd2, 1'b1, 64'h131, 3'd0, 1'b1, 64'h132, 3'd0);
    push_exp(4'd13, 64'h131, 64'h132, 3'd2);
    tick();
    set_alloc(4'd14, 3'd3, 1'b1, 64'h141, 3'd0, 1'b1, 64'h142, 3'd0);
    push_exp(4'd14, 64'h141, 64'h142, 3'd3);
    tick();
    set_alloc(4'd1, 3'd4, 1'b1, 64'h151, 3'd0, 1'b1, 64'h152, 3'd0);
    push_exp(4'd1, 64'h151, 64'h152, 3'd4);
    tick(); quiet();
    for (int k = 0; k < 5; k++) begin
      set_cdb(3'd6, 64'h5555);
      check("stall_valid", 64'(bus.iss_valid), 64'd1);
      check("stall_opcode", 64'(bus.iss_opcode), 64'd13);
      check("stall_op1", bus.iss_op1, 64'h131);
      check("stall_op2", bus.iss_op2, 64'h132);
      check("stall_dest", 64'(bus.iss_dest_tag), 64'd2);
      tick();
    end
    quiet();
    bus.iss_ready = 1'b1;
    tick();
    check("b2b_1_valid", 64'(bus.iss_valid), 64'd1);
    check("b2b_1_dest", 64'(bus.iss_dest_tag), 64'd3);
    tick();
    check("b2b_2_valid", 64'(bus.iss_valid), 64'd1);
    check("b2b_2_dest", 64'(bus.iss_dest_tag), 64'd4);
    tick();
    check("b2b_done", 64'(bus.iss_valid), 64'd0);

    // Synchronous flush with 3 occupied slots and a held issue
    bus.iss_ready = 1'b0;
    fill_ready_four();
    check("pre_flush_occ", 64'(bus.occupancy), 64'd3);
    check("pre_flush_valid", 64'(bus.iss_valid), 64'd1);
    flush = 1'b1;
    set_alloc(4'd9, 3'd5, 1'b1, 64'h9, 3'd0, 1'b1, 64'h9, 3'd0);
    set_cdb(3'd0, 64'h77);
    tick(); quiet();
    check("flush_valid", 64'(bus.iss_valid), 64'd0);
    check("flush_occ", 64'(bus.occupancy), 64'd0);
    check("flush_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    bus.iss_ready = 1'b1;
    repeat (3) tick();
    check("flush_alloc_dropped", 64'(bus.iss_valid), 64'd0);
    check("flush_occ_stays", 64'(bus.occupancy), 64'd0);

    // Asynchronous reset mid-cycle
    bus.iss_ready = 1'b0;
    fill_ready_four();
    check("pre_rst_valid", 64'(bus.iss_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.iss_valid), 64'd0);
    check("arst_occ", 64'(bus.occupancy), 64'd0);
    check("arst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("arst_opcode", 64'(bus.iss_opcode), 64'd0);
    check("arst_op1", bus.iss_op1, 64'd0);
    check("arst_dest", 64'(bus.iss_dest_tag), 64'd0);
    #3 rst_n = 1'b1;
    bus.iss_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", 64'(bus.iss_valid), 64'd0);
    check("post_rst_occ", 64'(bus.occupancy), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_reservation_station.md
# cdb_reservation_station

Reservation-station bank on the receiving end of the common data bus. Holds up to `ENTRIES` dispatched micro-ops, snoops every CDB broadcast (`valid`/`rs_id`/`result`) to capture outstanding source operands by tag, and issues the oldest fully-ready entry to its functional unit through a registered valid/ready port. It sits between the dispatch stage and one functional unit. The functional unit's completion later reaches the CDB arbiter.

## Interface
- `DATA_WIDTH`, 64: operand/result width.
- `TAG_WIDTH`, 3: producer tag width; matches the CDB `rs_id` width.
- `ENTRIES`, 4: number of station slots (2..16).
- `OPCODE_WIDTH`, 4: opaque opcode width, passed through unchanged.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; clears all entries and the issue register.
- `alloc_valid` in 1: dispatch offers a micro-op.
- `alloc_ready` out 1: a free slot exists.
- `alloc_opcode` in OPCODE_WIDTH: opcode.
- `alloc_dest_tag` in TAG_WIDTH: tag the result will carry on the CDB.
- `alloc_src1_rdy`, `alloc_src2_rdy` in 1 each: the operand value is already valid.
- `alloc_src1_val`, `alloc_src2_val` in DATA_WIDTH each: operand value, used when rdy=1.
- `alloc_src1_tag`, `alloc_src2_tag` in TAG_WIDTH each: producer tag, used when rdy=0.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_rs_id` in TAG_WIDTH: tag of the broadcasting producer.
- `cdb_result` in DATA_WIDTH: broadcast value.
- `iss_valid` out 1: issue register holds a micro-op.
- `iss_ready` in 1: functional unit accepts.
- `iss_opcode` out OPCODE_WIDTH, `iss_op1`/`iss_op2` out DATA_WIDTH each, `iss_dest_tag` out TAG_WIDTH: issued micro-op.
- `occupancy` out $clog2(ENTRIES+1): occupied slot count, issue register excluded.

## Operation
- Slot state: occupied, opcode, dest_tag, and for each operand: rdy, val, tag. Each slot also has an age rank; a lower rank means it was allocated earlier.
- Allocate: on `alloc_valid && alloc_ready`, the lowest-index free slot is written at the clock edge. Its age is youngest.
- Allocation bypass: if `cdb_valid` is high in the allocation cycle and `cdb_rs_id` equals a not-ready incoming source tag, that operand is written with rdy=1 and val=`cdb_result`.
- Snoop: each cycle with `cdb_valid` high, every occupied slot operand with rdy=0 and tag==`cdb_rs_id` captures `cdb_result` and sets rdy=1. Both operands of one slot can match at once. Multiple slots can match at once.
- Eligible: the slot is occupied and both rdy bits are registered high. A capture made in cycle N makes the slot eligible in cycle N+1. There is no same-cycle wakeup-select.
- Select: the oldest eligible slot is chosen. Age order is strict allocation order and is independent of slot index.
- Issue register load: loads when `!iss_valid || iss_ready`, and only if an eligible slot exists. The selected slot is freed on the same edge.
- If `iss_valid && iss_ready` and no slot is eligible, `iss_valid` clears.
- Stall: while `iss_valid && !iss_ready`, all `iss_*` outputs hold stable. Entries keep snooping.
- `alloc_ready` = occupancy < ENTRIES, computed from registered state. A slot freed at edge E is allocatable in the cycle after E. There is no free-to-alloc bypass in the same cycle.
- Flush: at the edge, all slots become free, `iss_valid` goes to 0, and `occupancy` goes to 0. An allocation or CDB capture in the flush cycle is discarded. Flush has priority over everything except reset.
- Reset (asynchronous, `rst_n` low): same state as flush. Reset mid-operation drops all contents immediately.
- Reset output values: `iss_valid`=0, `occupancy`=0, `alloc_ready`=1, `iss_opcode`/`iss_op1`/`iss_op2`/`iss_dest_tag`=0.
- Age tracking is an ENTRIES×ENTRIES older-than matrix or equivalent. It must survive arbitrary alloc/issue interleaving with no wrap hazard.

## Timing
- Minimum latency, allocation to issue: alloc accepted in cycle N with both rdy=1 → slot eligible in N+1 → `iss_valid` high in N+2.
- Minimum latency, CDB wakeup to issue: wakeup broadcast in cycle N → `iss_valid` high in N+2.
- Throughput: one issue per cycle while `iss_ready` is held high and eligible slots exist.
- Allocation throughput: one per cycle while `alloc_ready` is high.
- `occupancy` updates on the edge following an alloc or issue. Simultaneous alloc and issue leave it unchanged.

## Test plan
- Reset/idle: hold `rst_n`=0, then release. Required: `alloc_ready`=1, `occupancy`=0, `iss_valid`=0. Alloc opcode 3 with src1=5, src2=7, both rdy, `iss_ready`=1. Required: `iss_valid` two cycles later with op1=5, op2=7, opcode=3.
- Wakeup: alloc slot A with src1 tag 2 not ready and src2 rdy=9. Broadcast `cdb_rs_id`=2, `cdb_result`=0x1234 in cycle N. Required: `iss_valid` in N+2 with op1=0x1234, op2=9. A broadcast on tag 3 in the interim is ignored.
- Allocation bypass: alloc with src1 tag 4 not ready while `cdb_valid`=1, `cdb_rs_id`=4, result=0xAA in the same cycle. Required: issue two cycles later with op1=0xAA, with no further broadcast needed.
- Full/age order: fill 4 slots, all waiting on tag 1, with `iss_ready`=0. Required: `alloc_ready`=0 and `occupancy`=4. Free slot 0 by issuing a ready entry, then reallocate it so it becomes youngest. Broadcast tag 1. Required: issue order is strict allocation order, not slot index.
- Stall: hold `iss_ready`=0 for 5 cycles with `iss_valid`=1. Required: `iss_*` outputs stay stable. Raise `iss_ready` with two eligible slots. Required: back-to-back issue on consecutive cycles.
- Flush/reset mid-operation: with 3 occupied slots and `iss_valid`=1, assert `flush` for one cycle. Required: next cycle `iss_valid`=0 and `occupancy`=0. Repeat using asynchronous `rst_n` low mid-cycle. Required: outputs clear without waiting for a clock edge.
